// File: rtl/hazard_controller.sv
// hazard_controller: hazard and stall sequencer for the 5-stage RV32I pipeline.
//
// Keeps a shadow scoreboard of the E, M and W stage instructions and derives
// forwarding selects, load-use stalls, branch/jump flushes and a data-memory
// wait state machine from it.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   Rs1D, Rs2D, RdD               register fields of the instruction in D
//   RegWriteD, ResultSrcD         write-back controls of the instruction in D
//   PCSrcE                        branch taken / jump in E
//   MemReqM, MemReadyM            data-memory request in M / completion
//   StallF/D/E/M                  hold PC and pipeline registers
//   FlushD/E/W                    clear pipeline registers
//   ForwardAE, ForwardBE          operand selects (00 RF, 01 ResultW, 10 ALUResultM)
//   MemErr                        one-cycle pulse on memory wait timeout
//   StallCount                    saturating count of cycles with StallF=1
module hazard_controller #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount
);

    localparam logic [15:0] TimeoutVal = 16'(MEM_TIMEOUT);

    typedef enum logic {StRun, StMemWait} state_e;

    state_e           state_q;
    logic [15:0]      wait_cnt_q;
    logic [4:0]       rs1_e_q, rs2_e_q, rd_e_q, rd_m_q, rd_w_q;
    logic             reg_write_e_q, reg_write_m_q, reg_write_w_q;
    logic [1:0]       result_src_e_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic timeout_hit;
    logic mem_stall;
    logic lw_stall;
    logic branch;

    always_comb begin
        timeout_hit = (state_q == StMemWait) && (wait_cnt_q == TimeoutVal);
        mem_stall   = 1'b0;
        unique case (state_q)
            StRun:     mem_stall = MemReqM && !MemReadyM;
            StMemWait: mem_stall = !MemReadyM && !timeout_hit;
            default:   mem_stall = 1'b0;
        endcase
        // Gate with rst so every output drops to 0 while reset is held,
        // even if the pipeline keeps driving PCSrcE or MemReqM.
        mem_stall = mem_stall && !rst;
        lw_stall  = !rst && (result_src_e_q == 2'b01) && (rd_e_q != 5'd0) &&
                    ((rd_e_q == Rs1D) || (rd_e_q == Rs2D));
        branch    = !rst && PCSrcE;
    end

    always_comb begin
        // A taken branch must load the target PC, so it overrides the load-use hold.
        StallF = mem_stall || (lw_stall && !branch);
        StallD = StallF;
        StallE = mem_stall;
        StallM = mem_stall;
        FlushW = mem_stall;
        FlushD = !mem_stall && branch;
        FlushE = !mem_stall && (branch || lw_stall);
        MemErr = timeout_hit;

        // M stage holds the newer result, so it wins over W.
        if (reg_write_m_q && (rd_m_q != 5'd0) && (rd_m_q == rs1_e_q)) begin
            ForwardAE = 2'b10;
        end else if (reg_write_w_q && (rd_w_q != 5'd0) && (rd_w_q == rs1_e_q)) begin
            ForwardAE = 2'b01;
        end else begin
            ForwardAE = 2'b00;
        end

        if (reg_write_m_q && (rd_m_q != 5'd0) && (rd_m_q == rs2_e_q)) begin
            ForwardBE = 2'b10;
        end else if (reg_write_w_q && (rd_w_q != 5'd0) && (rd_w_q == rs2_e_q)) begin
            ForwardBE = 2'b01;
        end else begin
            ForwardBE = 2'b00;
        end
    end

    assign StallCount = stall_cnt_q;

    // Memory wait FSM. wait_cnt_q counts MEM_WAIT cycles, starting at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            wait_cnt_q <= 16'd0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (MemReqM && !MemReadyM) begin
                        state_q    <= StMemWait;
                        wait_cnt_q <= 16'd1;
                    end
                end
                StMemWait: begin
                    // A timeout ends the wait even if the memory answers in the same cycle.
                    if (timeout_hit || MemReadyM) begin
                        state_q    <= StRun;
                        wait_cnt_q <= 16'd0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q    <= StRun;
                    wait_cnt_q <= 16'd0;
                end
            endcase
        end
    end

    // Scoreboard advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_e_q        <= 5'd0;
            rs2_e_q        <= 5'd0;
            rd_e_q         <= 5'd0;
            reg_write_e_q  <= 1'b0;
            result_src_e_q <= 2'b00;
            rd_m_q         <= 5'd0;
            reg_write_m_q  <= 1'b0;
            rd_w_q         <= 5'd0;
            reg_write_w_q  <= 1'b0;
        end else if (mem_stall) begin
            rd_w_q        <= 5'd0;
            reg_write_w_q <= 1'b0;
        end else begin
            rd_w_q        <= rd_m_q;
            reg_write_w_q <= reg_write_m_q;
            rd_m_q        <= rd_e_q;
            reg_write_m_q <= reg_write_e_q;
            if (FlushE) begin
                rs1_e_q        <= 5'd0;
                rs2_e_q        <= 5'd0;
                rd_e_q         <= 5'd0;
                reg_write_e_q  <= 1'b0;
                result_src_e_q <= 2'b00;
            end else begin
                rs1_e_q        <= Rs1D;
                rs2_e_q        <= Rs2D;
                rd_e_q         <= RdD;
                reg_write_e_q  <= RegWriteD;
                result_src_e_q <= ResultSrcD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    Rs1D, Rs2D, RdD;
    logic          RegWriteD;
    logic [1:0]    ResultSrcD;
    logic          PCSrcE, MemReqM, MemReadyM;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          MemErr;
    logic [CW-1:0] StallCount;

    hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    // Reference model: instructions occupying E, M and W, plus memory wait progress.
    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
        logic [1:0] src;
    } ins_t;

    ins_t e_s, m_s, w_s;
    ins_t bubble = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, we: 1'b0, src: 2'b00};
    bit   busy;
    int   waited;
    int   scnt;
    int   checks = 0;
    int   errors = 0;

    logic x_sf, x_sd, x_se, x_sm, x_fd, x_fe, x_fw, x_err;
    logic [1:0] x_fa, x_fb;
    int   x_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (m_s.we && m_s.rd != 0 && m_s.rd == rs) return 2'b10;
        if (w_s.we && w_s.rd != 0 && w_s.rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        e_s = bubble; m_s = bubble; w_s = bubble;
        busy = 0; waited = 0; scnt = 0;
    endtask

    task automatic model_eval();
        logic ms, lw, br;
        x_cnt = scnt;
        if (rst) begin
            {x_sf, x_sd, x_se, x_sm, x_fd, x_fe, x_fw, x_err} = '0;
            x_fa = 2'b00; x_fb = 2'b00; x_cnt = 0;
        end else begin
            if (busy) ms = !MemReadyM && (waited < TO);
            else      ms = MemReqM && !MemReadyM;
            lw = (e_s.src == 2'b01) && (e_s.rd != 0) && (e_s.rd == Rs1D || e_s.rd == Rs2D);
            br = PCSrcE;
            x_sf = ms || (lw && !br);
            x_sd = x_sf;
            x_se = ms; x_sm = ms; x_fw = ms;
            x_fd = !ms && br;
            x_fe = !ms && (br || lw);
            x_fa = fwd(e_s.rs1);
            x_fb = fwd(e_s.rs2);
            x_err = busy && (waited == TO);
        end
    endtask

    task automatic check_all();
        model_eval();
        chk("StallF", StallF, x_sf);
        chk("StallD", StallD, x_sd);
        chk("StallE", StallE, x_se);
        chk("StallM", StallM, x_sm);
        chk("FlushD", FlushD, x_fd);
        chk("FlushE", FlushE, x_fe);
        chk("FlushW", FlushW, x_fw);
        chk("ForwardAE", ForwardAE, x_fa);
        chk("ForwardBE", ForwardBE, x_fb);
        chk("MemErr", MemErr, x_err);
        chk("StallCount", StallCount, x_cnt);
    endtask

    task automatic model_next();
        ins_t d;
        d = '{rs1: Rs1D, rs2: Rs2D, rd: RdD, we: RegWriteD, src: ResultSrcD};
        if (x_sf) scnt = (scnt == CNT_MAX) ? scnt : scnt + 1;
        if (busy) begin
            if (waited == TO || MemReadyM) busy = 0;
            else waited++;
        end else if (MemReqM && !MemReadyM) begin
            busy = 1; waited = 1;
        end
        if (x_se) begin
            w_s = bubble;
        end else begin
            w_s = m_s; m_s = e_s;
            e_s = x_fe ? bubble : d;
        end
    endtask

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic we, input logic [1:0] src, input logic pc,
                         input logic req, input logic rdy);
        @(negedge clk);
        Rs1D = r1; Rs2D = r2; RdD = rd; RegWriteD = we; ResultSrcD = src;
        PCSrcE = pc; MemReqM = req; MemReadyM = rdy;
        #2;
        check_all();
    endtask

    task automatic adv();
        model_next();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges; inputs are left as they are.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #2;
        check_all();
        chk("rst_stallF", StallF, 1'b0);
        chk("rst_flushW", FlushW, 1'b0);
        chk("rst_fwdA", ForwardAE, 2'b00);
        chk("rst_count", StallCount, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        Rs1D = 0; Rs2D = 0; RdD = 0; RegWriteD = 0; ResultSrcD = 0;
        PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
        model_reset();
        do_reset();

        // addi x5 ; add x6,x5,x1 ; sub x9,x5,x6
        drive(5'd0, 5'd0, 5'd5, 1, 2'b00, 0, 0, 0); adv();
        drive(5'd5, 5'd1, 5'd6, 1, 2'b00, 0, 0, 0); adv();
        drive(5'd5, 5'd6, 5'd9, 1, 2'b00, 0, 0, 0);
        chk("fwd_add_A_M", ForwardAE, 2'b10);
        chk("fwd_add_B_none", ForwardBE, 2'b00);
        adv();
        drive(5'd0, 5'd0, 5'd0, 0, 2'b00, 0, 0, 0);
        chk("fwd_sub_A_W", ForwardAE, 2'b01);
        chk("fwd_sub_B_M", ForwardBE, 2'b10);
        adv();

        // lw x7 ; add x8,x7,x7
        do_reset();
        drive(5'd0, 5'd0, 5'd7, 1, 2'b01, 0, 0, 0); adv();
        drive(5'd7, 5'd7, 5'd8, 1, 2'b00, 0, 0, 0);
        chk("lu_stallF", StallF, 1'b1);
        chk("lu_stallD", StallD, 1'b1);
        chk("lu_flushE", FlushE, 1'b1);
        chk("lu_stallE", StallE, 1'b0);
        adv();
        drive(5'd7, 5'd7, 5'd8, 1, 2'b00, 0, 0, 0);
        chk("lu_released", StallF, 1'b0);
        adv();
        drive(5'd0, 5'd0, 5'd0, 0, 2'b00, 0, 0, 0);
        chk("lu_fwdA", ForwardAE, 2'b01);
        chk("lu_fwdB", ForwardBE, 2'b01);
        chk("lu_count", StallCount, 1);
        adv();

        // Branch while a load-use hazard is pending
        do_reset();
        drive(5'd0, 5'd0, 5'd7, 1, 2'b01, 0, 0, 0); adv();
        drive(5'd7, 5'd0, 5'd8, 1, 2'b00, 1, 0, 0);
        chk("br_flushD", FlushD, 1'b1);
        chk("br_flushE", FlushE, 1'b1);
        chk("br_stallF", StallF, 1'b0);
        chk("br_stallD", StallD, 1'b0);
        adv();

        // Three-cycle memory wait
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 5'd0, 0, 2'b00, (i == 1), 1, 0);
            chk("mw_stallF", StallF, 1'b1);
            chk("mw_stallM", StallM, 1'b1);
            chk("mw_flushW", FlushW, 1'b1);
            chk("mw_flushD_masked", FlushD, 1'b0);
            adv();
        end
        drive(5'd0, 5'd0, 5'd0, 0, 2'b00, 0, 1, 1);
        chk("mw_release_F", StallF, 1'b0);
        chk("mw_release_M", StallM, 1'b0);
        adv();
        drive(5'd0, 5'd0, 5'd0, 0, 2'b00, 0, 0, 0);
        chk("mw_count", StallCount, 3);
        adv();

        // Timeout with memory stuck not ready
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(5'd0, 5'd0, 5'd0, 0, 2'b00, 0, 1, 0);
            chk("to_memerr", MemErr, (i == 4));
            chk("to_stall", StallF, (i != 4));
            adv();
        end
        drive(5'd0, 5'd0, 5'd0, 0, 2'b00, 0, 0, 0);
        chk("to_pulse_end", MemErr, 1'b0);
        adv();

        // Reset mid-forward and mid-wait, then x0 handling
        do_reset();
        drive(5'd0, 5'd0, 5'd5, 1, 2'b00, 0, 0, 0); adv();
        drive(5'd5, 5'd5, 5'd6, 1, 2'b00, 0, 0, 0); adv();
        drive(5'd5, 5'd5, 5'd0, 0, 2'b00, 0, 1, 0);
        chk("mid_fwd", ForwardAE, 2'b10);
        chk("mid_stall", StallF, 1'b1);
        adv();
        do_reset();
        drive(5'd0, 5'd0, 5'd0, 1, 2'b01, 0, 0, 0); adv();
        drive(5'd0, 5'd0, 5'd3, 1, 2'b00, 0, 0, 0);
        chk("x0_no_stall", StallF, 1'b0);
        chk("x0_no_flush", FlushE, 1'b0);
        adv();
        drive(5'd0, 5'd0, 5'd0, 0, 2'b00, 0, 0, 0);
        chk("x0_no_fwd", ForwardAE, 2'b00);
        adv();

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
                adv();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
